// File: rtl/rtc_cfg_sched_pkg.sv
// Shared encodings and default widths for the rtc_timer configuration scheduler.
// Op codes, FSM states and the eligibility rule live here so every file agrees on them.
package rtc_ctrl_pkg;

    localparam int PER_W = 40;
    localparam int NS_W  = 38;
    localparam int SEC_W = 48;
    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        OP_PERIOD = 2'd0,
        OP_TIME   = 2'd1,
        OP_ADJ    = 2'd2,
        OP_ILL    = 2'd3
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // TIME/ADJ must not disturb a running adjust; TIME may cancel it when abort is enabled.
    function automatic logic op_eligible(input op_e op, input logic busy, input logic abort_en);
        case (op)
            OP_TIME: return !busy || abort_en;
            OP_ADJ:  return !busy;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/rtc_cfg_sched_if.sv
// Command channel from one requester (host or servo) into the scheduler.
// valid/op/payload driven by the requester, ready returned by the scheduler.
interface rtc_cmd_if #(
    parameter int PER_W = rtc_ctrl_pkg::PER_W,
    parameter int NS_W  = rtc_ctrl_pkg::NS_W,
    parameter int SEC_W = rtc_ctrl_pkg::SEC_W,
    parameter int CNT_W = rtc_ctrl_pkg::CNT_W
);
    logic             valid;
    logic             ready;
    logic [1:0]       op;
    logic [PER_W-1:0] per;
    logic [CNT_W-1:0] cnt;
    logic [NS_W-1:0]  ns;
    logic [SEC_W-1:0] sec;

    modport master (output valid, op, per, cnt, ns, sec, input ready);
    modport slave  (input valid, op, per, cnt, ns, sec, output ready);
endinterface

// File: rtl/rtc_adj_window.sv
// Fine-adjust window tracker: loads a cycle count, then counts down to 0 and stops there.
// busy is high while the count is nonzero; a load of 0 cancels any window in progress.
module rtc_adj_window #(
    parameter int CNT_W = rtc_ctrl_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             busy
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= cnt_in;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/rtc_cfg_sched.sv
// Arbitrates host/servo commands into single-cycle rtc_timer load pulses (accept N -> pulse N+1).
// Optional RTC_ADJ_ABORT_EN: TIME may cancel an active adjust window instead of waiting for it.
module rtc_cfg_sched
    import rtc_ctrl_pkg::*;
#(
    parameter int PER_W = rtc_ctrl_pkg::PER_W,
    parameter int NS_W  = rtc_ctrl_pkg::NS_W,
    parameter int SEC_W = rtc_ctrl_pkg::SEC_W,
    parameter int CNT_W = rtc_ctrl_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    rtc_cmd_if.slave         h,
    rtc_cmd_if.slave         s,
    output logic             period_ld,
    output logic [PER_W-1:0] period_in,
    output logic             time_ld,
    output logic [NS_W-1:0]  time_reg_ns_in,
    output logic [SEC_W-1:0] time_reg_sec_in,
    output logic             adj_ld,
    output logic [CNT_W-1:0] adj_ld_data,
    output logic [PER_W-1:0] period_adj,
    output logic             adj_busy,
    output logic             cmd_done,
    output logic             cmd_src,
    output logic             cmd_err
);
`ifdef RTC_ADJ_ABORT_EN
    localparam logic ABORT_EN = 1'b1;
`else
    localparam logic ABORT_EN = 1'b0;
`endif

    state_e           state;
    logic             prio;      // 0: host wins a tie, 1: servo wins a tie
    logic             h_req, s_req, grant_h, grant_s, accept, abort;
    op_e              sel_op;
    logic [PER_W-1:0] sel_per;
    logic [CNT_W-1:0] sel_cnt;
    logic [NS_W-1:0]  sel_ns;
    logic [SEC_W-1:0] sel_sec;
    logic             win_load;
    logic [CNT_W-1:0] win_cnt;

    always_comb begin
        h_req   = h.valid && op_eligible(op_e'(h.op), adj_busy, ABORT_EN);
        s_req   = s.valid && op_eligible(op_e'(s.op), adj_busy, ABORT_EN);
        grant_h = (state == IDLE) && h_req && (!s_req || !prio);
        grant_s = (state == IDLE) && s_req && !grant_h;
        accept  = grant_h || grant_s;

        sel_op  = grant_s ? op_e'(s.op) : op_e'(h.op);
        sel_per = grant_s ? s.per : h.per;
        sel_cnt = grant_s ? s.cnt : h.cnt;
        sel_ns  = grant_s ? s.ns  : h.ns;
        sel_sec = grant_s ? s.sec : h.sec;

        abort    = ABORT_EN && (sel_op == OP_TIME) && adj_busy;
        win_load = accept && ((sel_op == OP_ADJ) || abort);
        win_cnt  = (sel_op == OP_ADJ) ? sel_cnt : '0;
    end

    assign h.ready = grant_h;
    assign s.ready = grant_s;

    // The counter loads on the accept edge, so the ISSUE cycle already reports busy.
    rtc_adj_window #(.CNT_W(CNT_W)) u_adj_window (
        .clk    (clk),
        .rst    (rst),
        .load   (win_load),
        .cnt_in (win_cnt),
        .busy   (adj_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            prio            <= 1'b0;
            period_ld       <= 1'b0;
            period_in       <= '0;
            time_ld         <= 1'b0;
            time_reg_ns_in  <= '0;
            time_reg_sec_in <= '0;
            adj_ld          <= 1'b0;
            adj_ld_data     <= '0;
            period_adj      <= '0;
            cmd_done        <= 1'b0;
            cmd_src         <= 1'b0;
            cmd_err         <= 1'b0;
        end else begin
            period_ld <= 1'b0;
            time_ld   <= 1'b0;
            adj_ld    <= 1'b0;
            cmd_done  <= 1'b0;
            cmd_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= ISSUE;
                        prio    <= grant_h;
                        cmd_src <= grant_s;
                        case (sel_op)
                            OP_PERIOD: begin
                                period_ld <= 1'b1;
                                period_in <= sel_per;
                                cmd_done  <= 1'b1;
                            end
                            OP_TIME: begin
                                time_ld         <= 1'b1;
                                time_reg_ns_in  <= sel_ns;
                                time_reg_sec_in <= sel_sec;
                                cmd_done        <= 1'b1;
                                if (abort) begin
                                    adj_ld      <= 1'b1;
                                    adj_ld_data <= '0;
                                    period_adj  <= '0;
                                end
                            end
                            OP_ADJ: begin
                                adj_ld      <= 1'b1;
                                adj_ld_data <= sel_cnt;
                                period_adj  <= sel_per;
                                cmd_done    <= 1'b1;
                            end
                            default: cmd_err <= 1'b1;
                        endcase
                    end
                end
                ISSUE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
